fifo_sync_prog: RTL

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_sync_prog.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with a count-based status, programmable almost-full/empty levels,
// sticky overflow/underflow flags and a selectable registered or fall-through read port.
module fifo_sync_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_set;
  logic             unf_set;

  // Handshake: a write is taken only while !full and a read only while !empty, both
  // judged on the state at the start of the cycle; a refused request sets its sticky
  // error flag. Flush suppresses both requests and raises no error.
  assign wr_acc  = reset && !flush && wr_en && !full;
  assign rd_acc  = reset && !flush && rd_en && !empty;
  assign ovf_set = !flush && wr_en && full;
  assign unf_set = !flush && rd_en && empty;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
        if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) rd_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule
